// File: rtl/key_event_decoder_if.sv
// Key event bundle: debounced key level/qualifier in, gesture pulses and held level out.
// Latency: none (wires only).
// Backpressure: none; events are single-cycle pulses that the consumer must catch.
interface key_event_decoder_if;
  logic key_level;
  logic key_valid;
  logic press_pulse;
  logic release_pulse;
  logic short_press;
  logic long_press;
  logic double_click;
  logic key_held;

  // Producer side: drives the key samples, observes the events
  modport master (
    output key_level, key_valid,
    input  press_pulse, release_pulse, short_press, long_press, double_click, key_held
  );

  // Decoder side: consumes the key samples, produces the events
  modport slave (
    input  key_level, key_valid,
    output press_pulse, release_pulse, short_press, long_press, double_click, key_held
  );
endinterface

// File: rtl/key_event_decoder.sv
// Turns a debounced key level into press/release/short/long/double-click pulses.
// Latency: every output is registered, visible the edge after the qualifying sample.
// Backpressure: none; samples with key_valid=0 are ignored, timers keep running.
module key_event_decoder #(
  parameter int LONG_PRESS_MS = 1000,
  parameter int DBL_GAP_MS    = 250,
  parameter int CNT_W         = 16
) (
  input  logic            clk_1Khz,
  input  logic            rst_n,
  key_event_decoder_if.slave kev
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESSED   = 3'd1,
    LONG_HELD = 3'd2,
    WAIT_GAP  = 3'd3,
    PRESSED2  = 3'd4
  } state_t;

  // Compare-equal thresholds; the counter stops here so it can never wrap
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_MS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DBL_GAP_MS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             short_q, short_d;
  logic             long_q, long_d;
  logic             dbl_q, dbl_d;
  logic             held_q, held_d;

  logic press_s;
  logic release_s;

  assign press_s   = kev.key_valid &  kev.key_level;
  assign release_s = kev.key_valid & ~kev.key_level;

  // Next-state, timer and event decode; release/press win over timer expiry
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    short_d   = 1'b0;
    long_d    = 1'b0;
    dbl_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (press_s) begin
          state_d = PRESSED;
          cnt_d   = '0;
          press_d = 1'b1;
        end
      end
      PRESSED: begin
        if (release_s) begin
          state_d   = WAIT_GAP;
          cnt_d     = '0;
          release_d = 1'b1;
        end else if (cnt_q == LONG_LAST) begin
          state_d = LONG_HELD;
          long_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      LONG_HELD: begin
        if (release_s) begin
          state_d   = IDLE;
          release_d = 1'b1;
        end
      end
      WAIT_GAP: begin
        if (press_s) begin
          state_d = PRESSED2;
          cnt_d   = '0;
          press_d = 1'b1;
        end else if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          short_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRESSED2: begin
        if (release_s) begin
          state_d   = IDLE;
          release_d = 1'b1;
          dbl_d     = 1'b1;
        end else if (cnt_q == LONG_LAST) begin
          // Held too long for a double click: it becomes a long press instead
          state_d = LONG_HELD;
          long_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    held_d = (state_d == PRESSED) || (state_d == LONG_HELD) || (state_d == PRESSED2);
  end

  // State, timer and registered outputs; reset aborts any gesture silently
  always_ff @(posedge clk_1Khz or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
      dbl_q     <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      short_q   <= short_d;
      long_q    <= long_d;
      dbl_q     <= dbl_d;
      held_q    <= held_d;
    end
  end

  assign kev.press_pulse   = press_q;
  assign kev.release_pulse = release_q;
  assign kev.short_press   = short_q;
  assign kev.long_press    = long_q;
  assign kev.double_click  = dbl_q;
  assign kev.key_held      = held_q;

endmodule

// File: tb/tb_key_event_decoder.sv
// Scoreboard bench for key_event_decoder with LONG_PRESS_MS=8, DBL_GAP_MS=4.
// Stimulus pushes expected (edge, event) records; the monitor pops on every output event.
// Inputs change 1 time unit after a rising edge, outputs are sampled on the falling edge.
module tb_key_event_decoder;

  localparam logic [4:0] EV_P = 5'b10000;
  localparam logic [4:0] EV_R = 5'b01000;
  localparam logic [4:0] EV_S = 5'b00100;
  localparam logic [4:0] EV_L = 5'b00010;
  localparam logic [4:0] EV_D = 5'b00001;

  typedef struct {
    int         cyc;
    logic [4:0] ev;
  } exp_t;

  logic clk_1Khz = 1'b0;
  logic rst_n    = 1'b0;
  int   cyc      = 0;
  int   checks   = 0;
  int   errors   = 0;
  exp_t exp_q[$];

  key_event_decoder_if kif ();

  key_event_decoder #(
    .LONG_PRESS_MS(8),
    .DBL_GAP_MS   (4),
    .CNT_W        (16)
  ) dut (
    .clk_1Khz(clk_1Khz),
    .rst_n   (rst_n),
    .kev     (kif.slave)
  );

  always #5 clk_1Khz = ~clk_1Khz;

  // Edge counter: after rising edge n, cyc == n
  always @(posedge clk_1Khz) cyc <= cyc + 1;

  // Monitor: any event, or a cycle where one is due, consumes one scoreboard entry
  logic [4:0] mon_ev;
  exp_t       mon_e;
  always @(negedge clk_1Khz) begin
    if (rst_n) begin
      mon_ev = {kif.press_pulse, kif.release_pulse, kif.short_press,
                kif.long_press, kif.double_click};
      if (mon_ev != 5'b0 || (exp_q.size() > 0 && exp_q[0].cyc == cyc)) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event cyc=%0d got ev=%b want none", cyc, mon_ev);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.cyc != cyc || mon_e.ev != mon_ev) begin
            errors++;
            $display("FAIL event cyc=%0d got ev=%b want ev=%b at cyc=%0d",
                     cyc, mon_ev, mon_e.ev, mon_e.cyc);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_1Khz);
      #1;
    end
  endtask

  task automatic set_in(input logic lvl, input logic vld);
    kif.key_level = lvl;
    kif.key_valid = vld;
  endtask

  task automatic push(input int at, input logic [4:0] ev);
    exp_t e;
    e.cyc = at;
    e.ev  = ev;
    exp_q.push_back(e);
  endtask

  task automatic check_held(input string name, input logic want);
    checks++;
    if (kif.key_held !== want) begin
      errors++;
      $display("FAIL %s key_held got %b want %b", name, kif.key_held, want);
    end
  endtask

  task automatic check_all_zero(input string name);
    logic [5:0] got;
    got = {kif.press_pulse, kif.release_pulse, kif.short_press,
           kif.long_press, kif.double_click, kif.key_held};
    checks++;
    if (got !== 6'b0) begin
      errors++;
      $display("FAIL %s outputs got %b want 000000", name, got);
    end
  endtask

  int c;

  initial begin
    set_in(1'b0, 1'b0);
    tick(2);
    check_all_zero("reset_state");
    rst_n = 1'b1;
    tick(2);
    check_all_zero("post_reset_idle");

    // Short press: 3 cycles held, short_press 4 cycles after release
    c = cyc;
    set_in(1'b1, 1'b1);
    push(c + 1, EV_P);
    tick(1);
    check_held("short_held_on", 1'b1);
    tick(2);
    check_held("short_held_3rd", 1'b1);
    set_in(1'b0, 1'b1);
    push(c + 4, EV_R);
    push(c + 8, EV_S);
    tick(1);
    check_held("short_held_off", 1'b0);
    tick(7);

    // Long press: held 20 cycles, long 8 after press, release without short
    c = cyc;
    set_in(1'b1, 1'b1);
    push(c + 1, EV_P);
    push(c + 9, EV_L);
    tick(20);
    check_held("long_held", 1'b1);
    set_in(1'b0, 1'b1);
    push(c + 21, EV_R);
    tick(1);
    check_held("long_released", 1'b0);
    tick(8);

    // Release on the long threshold edge wins: release then short
    c = cyc;
    set_in(1'b1, 1'b1);
    push(c + 1, EV_P);
    tick(8);
    set_in(1'b0, 1'b1);
    push(c + 9, EV_R);
    push(c + 13, EV_S);
    tick(8);

    // Double click: press 2, release 2, press 2, release
    c = cyc;
    set_in(1'b1, 1'b1);
    push(c + 1, EV_P);
    tick(2);
    set_in(1'b0, 1'b1);
    push(c + 3, EV_R);
    tick(2);
    set_in(1'b1, 1'b1);
    push(c + 5, EV_P);
    tick(2);
    set_in(1'b0, 1'b1);
    push(c + 7, EV_R | EV_D);
    tick(1);
    check_held("dbl_released", 1'b0);
    tick(8);

    // Second press sampled on the gap timeout edge still makes a double click
    c = cyc;
    set_in(1'b1, 1'b1);
    push(c + 1, EV_P);
    tick(2);
    set_in(1'b0, 1'b1);
    push(c + 3, EV_R);
    tick(4);
    set_in(1'b1, 1'b1);
    push(c + 7, EV_P);
    tick(2);
    set_in(1'b0, 1'b1);
    push(c + 9, EV_R | EV_D);
    tick(9);

    // Second press one cycle past the timeout: short, then a fresh single press
    c = cyc;
    set_in(1'b1, 1'b1);
    push(c + 1, EV_P);
    tick(2);
    set_in(1'b0, 1'b1);
    push(c + 3, EV_R);
    push(c + 7, EV_S);
    tick(5);
    set_in(1'b1, 1'b1);
    push(c + 8, EV_P);
    tick(2);
    set_in(1'b0, 1'b1);
    push(c + 10, EV_R);
    push(c + 14, EV_S);
    tick(9);

    // Second press held to the long threshold: long press, no double click
    c = cyc;
    set_in(1'b1, 1'b1);
    push(c + 1, EV_P);
    tick(2);
    set_in(1'b0, 1'b1);
    push(c + 3, EV_R);
    tick(2);
    set_in(1'b1, 1'b1);
    push(c + 5, EV_P);
    push(c + 13, EV_L);
    tick(10);
    set_in(1'b0, 1'b1);
    push(c + 15, EV_R);
    tick(9);

    // key_valid=0 with a toggling level: nothing happens, still IDLE
    for (int i = 0; i < 10; i++) begin
      set_in(1'($urandom_range(0, 1)), 1'b0);
      tick(1);
    end
    check_all_zero("invalid_ignored");
    c = cyc;
    set_in(1'b1, 1'b1);
    push(c + 1, EV_P);
    tick(2);
    set_in(1'b0, 1'b1);
    push(c + 3, EV_R);
    push(c + 7, EV_S);
    tick(8);

    // Async reset mid-PRESSED (cnt=5) aborts silently, then a fresh long press
    c = cyc;
    set_in(1'b1, 1'b1);
    push(c + 1, EV_P);
    tick(6);
    check_held("pre_reset_held", 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    tick(1);
    check_all_zero("in_reset");
    rst_n = 1'b1;
    c = cyc;
    push(c + 1, EV_P);
    push(c + 9, EV_L);
    tick(1);
    check_held("post_reset_press", 1'b1);
    tick(10);
    set_in(1'b0, 1'b1);
    push(c + 12, EV_R);
    tick(8);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending want 0 (next ev=%b at cyc=%0d)",
               exp_q.size(), exp_q[0].ev, exp_q[0].cyc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
